// File: rtl/counter_pkg.sv
// Shared definitions for the modulo counter family.
// Cascaded stages (sec/min/hour) and their benches use the same state type.
package counter_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2
  } counter_state_t;

endpackage : counter_pkg

// File: rtl/counter_modulo_if.sv
// Control and status bundle for one counter_modulo stage.
// The master drives the controls; the counter side returns the count and flags.
interface counter_modulo_if #(
  parameter int WIDTH = 6
);

  logic             en;
  logic             carry_in;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] count_value;
  logic             carry_out;
  logic             load_err;

  modport master (
    output en, carry_in, up_dn, load, load_value,
    input  count_value, carry_out, load_err
  );

  modport slave (
    input  en, carry_in, up_dn, load, load_value,
    output count_value, carry_out, load_err
  );

endinterface : counter_modulo_if

// File: rtl/counter_modulo.sv
// Up/down modulo-N counter with synchronous load, clamped out-of-range loads,
// and a same-cycle carry_out so chained stages step on the wrap edge.
module counter_modulo
  import counter_pkg::*;
#(
  parameter int WIDTH       = 6,
  parameter int MODULUS     = 60,
  parameter int RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             carry_in,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count_value,
  output logic             carry_out,
  output logic             load_err
);

  if (MODULUS < 2 || MODULUS > (1 << WIDTH) ||
      RESET_VALUE < 0 || RESET_VALUE >= MODULUS) begin : g_param_check
    $error("counter_modulo: illegal WIDTH/MODULUS/RESET_VALUE combination");
  end

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_C = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1);

  counter_state_t   state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             load_err_q;
  logic             load_err_d;
  logic             at_wrap;
  logic             step;

  assign at_wrap = up_dn ? (count_q == MAX_C) : (count_q == '0);

  // Gating with rst keeps a reset edge from also issuing a carry to the next stage.
  assign step      = rst && (state_q == ST_RUN) && carry_in && !load;
  assign carry_out = step && at_wrap;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    count_d    = count_q;
    load_err_d = load && (load_value > MAX_C);
    if (load) begin
      count_d = (load_value > MAX_C) ? MAX_C : load_value;
    end else if (step) begin
      if (up_dn) count_d = at_wrap ? '0 : count_q + ONE_C;
      else       count_d = at_wrap ? MAX_C : count_q - ONE_C;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values; reset is synchronous and wins over everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_RESET;
      count_q    <= RST_C;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= en ? ST_RUN : ST_HOLD;
      count_q    <= count_d;
      load_err_q <= load_err_d;
    end
  end

  assign count_value = count_q;
  assign load_err    = load_err_q;

endmodule : counter_modulo
